// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the 8-way round-robin bus arbiter.
package bus_arb_pkg;

    localparam int NUM_REQ   = 8;
    localparam int SEL_WIDTH = 3;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        TURN
    } state_t;

    typedef logic [SEL_WIDTH-1:0] sel_t;
    typedef logic [NUM_REQ-1:0]   req_t;

    function automatic req_t onehot(input sel_t idx);
        req_t v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin picker: rotate past Last, take the lowest set
// bit, then map the rotated position back to a requester index.
module rr_pick8
    import bus_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0]   Req,
    input  logic [SEL_WIDTH-1:0] Last,
    output logic                 Any,
    output logic [SEL_WIDTH-1:0] Idx
);

    sel_t start;
    sel_t pos;
    sel_t k;
    req_t rot;

    always_comb begin
        start = Last + 3'd1;
        rot   = '0;
        k     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k      = start + SEL_WIDTH'(i);
            rot[i] = Req[k];
        end
        pos = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) pos = SEL_WIDTH'(i);
        end
        Idx = pos + start;
        Any = |Req;
    end

endmodule

// File: rtl/bus_arbiter8.sv
// 8-requester round-robin bus arbiter with one-cycle turnaround.
// Optional per-tenure hold limit enabled by macro BUS_ARB_TIMEOUT_EN.
module bus_arbiter8
    import bus_arb_pkg::*;
#(
    parameter int MAX_HOLD  = 16,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic [NUM_REQ-1:0]   Req,
    input  logic                 Done,
    output logic [NUM_REQ-1:0]   Gnt,
    output logic [SEL_WIDTH-1:0] Sel,
    output logic                 BusValid,
    output logic                 TimeoutErr
);

    if (MAX_HOLD < 2 || MAX_HOLD > 255 ||
        CNT_WIDTH < $clog2(MAX_HOLD + 1)) begin : g_bad_cfg
        $error("bus_arbiter8: MAX_HOLD/CNT_WIDTH out of range");
    end

    state_t state;
    state_t state_nx;
    sel_t   last;
    sel_t   last_nx;
    sel_t   sel_nx;
    req_t   gnt_nx;
    logic   valid_nx;
    logic   any;
    sel_t   idx;
    logic   rel;
    logic   hold_to;

    rr_pick8 u_pick (
        .Req  (Req),
        .Last (last),
        .Any  (any),
        .Idx  (idx)
    );

    assign rel = Done || !Req[Sel];

`ifdef BUS_ARB_TIMEOUT_EN
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_nx;
    logic                 terr_nx;
    logic                 terr_q;

    assign hold_to    = (cnt == CNT_WIDTH'(MAX_HOLD));
    assign TimeoutErr = terr_q;
`else
    assign hold_to    = 1'b0;
    assign TimeoutErr = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        last_nx  = last;
        sel_nx   = Sel;
        gnt_nx   = Gnt;
        valid_nx = BusValid;
`ifdef BUS_ARB_TIMEOUT_EN
        cnt_nx   = cnt;
        terr_nx  = 1'b0;
`endif
        unique case (state)
            IDLE, TURN: begin
                gnt_nx   = '0;
                valid_nx = 1'b0;
                state_nx = IDLE;
                if (any) begin
                    state_nx = GRANT;
                    gnt_nx   = onehot(idx);
                    sel_nx   = idx;
                    last_nx  = idx;
                    valid_nx = 1'b1;
`ifdef BUS_ARB_TIMEOUT_EN
                    cnt_nx   = CNT_WIDTH'(1);
`endif
                end
            end
            GRANT: begin
                // Done/drop outranks the hold limit, so a clean end never flags
                if (rel || hold_to) begin
                    state_nx = TURN;
                    gnt_nx   = '0;
                    valid_nx = 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
                    terr_nx  = !rel;
                end else begin
                    cnt_nx   = cnt + CNT_WIDTH'(1);
`endif
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= IDLE;
            last     <= 3'd7;
            Sel      <= '0;
            Gnt      <= '0;
            BusValid <= 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
            cnt      <= '0;
            terr_q   <= 1'b0;
`endif
        end else begin
            state    <= state_nx;
            last     <= last_nx;
            Sel      <= sel_nx;
            Gnt      <= gnt_nx;
            BusValid <= valid_nx;
`ifdef BUS_ARB_TIMEOUT_EN
            cnt      <= cnt_nx;
            terr_q   <= terr_nx;
`endif
        end
    end

endmodule

// File: tb/tb_bus_arbiter8.sv
// Directed bench for bus_arbiter8; the hold-limit section follows
// whether BUS_ARB_TIMEOUT_EN is defined for the build.
module tb_bus_arbiter8;

    logic       Clk     = 1'b0;
    logic       Reset_n = 1'b0;
    logic [7:0] Req     = 8'h00;
    logic       Done    = 1'b0;
    logic [7:0] Gnt;
    logic [2:0] Sel;
    logic       BusValid;
    logic       TimeoutErr;

    int errors = 0;
    int checks = 0;

    always #5 Clk = ~Clk;

    bus_arbiter8 #(
        .MAX_HOLD  (4),
        .CNT_WIDTH (8)
    ) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .Req        (Req),
        .Done       (Done),
        .Gnt        (Gnt),
        .Sel        (Sel),
        .BusValid   (BusValid),
        .TimeoutErr (TimeoutErr)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
        chk("busvalid_is_or_gnt", {31'd0, BusValid}, {31'd0, |Gnt});
        chk("gnt_onehot0", {31'd0, $onehot0(Gnt)}, 32'd1);
    endtask

    task automatic expect_gnt(input string tag, input int idx);
        logic [7:0] g;
        g = 8'd1 << idx;
        chk({tag, "_gnt"}, {24'd0, Gnt}, {24'd0, g});
        chk({tag, "_sel"}, {29'd0, Sel}, idx);
        chk({tag, "_valid"}, {31'd0, BusValid}, 32'd1);
    endtask

    task automatic expect_turn(input string tag, input int idx);
        chk({tag, "_gnt"}, {24'd0, Gnt}, 32'd0);
        chk({tag, "_valid"}, {31'd0, BusValid}, 32'd0);
        chk({tag, "_sel"}, {29'd0, Sel}, idx);
    endtask

    initial begin
        #2;
        chk("rst_gnt", {24'd0, Gnt}, 32'd0);
        chk("rst_sel", {29'd0, Sel}, 32'd0);
        chk("rst_valid", {31'd0, BusValid}, 32'd0);
        chk("rst_terr", {31'd0, TimeoutErr}, 32'd0);
        @(posedge Clk);
        #1;
        chk("rst_hold_gnt", {24'd0, Gnt}, 32'd0);

        // single requester 0
        Reset_n = 1'b1;
        Req     = 8'h01;
        tick();
        expect_gnt("first", 0);
        Req = 8'h00;
        tick();
        expect_turn("first_turn", 0);
        tick();
        expect_turn("first_idle", 0);

        // fresh reset, all requesting, Done on 3rd cycle
        Reset_n = 1'b0;
        #2;
        Reset_n = 1'b1;
        Req     = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            tick();
            expect_gnt("rr", k % 8);
            tick();
            tick();
            Done = 1'b1;
            tick();
            Done = 1'b0;
            expect_turn("rr_turn", k % 8);
        end

        // owner 3 ignores others, then drops its request
        Req = 8'h08;
        tick();
        expect_gnt("own3", 3);
        Req = 8'h09;
        tick();
        expect_gnt("own3_hold", 3);
        Req = 8'h00;
        tick();
        expect_turn("own3_turn", 3);
        tick();
        expect_turn("own3_idle", 3);
        tick();
        chk("own3_sel_kept", {29'd0, Sel}, 32'd3);

        // previous owner loses to another requester after turnaround
        Req = 8'h08;
        tick();
        expect_gnt("again3", 3);
        Req  = 8'h09;
        Done = 1'b1;
        tick();
        Done = 1'b0;
        expect_turn("again3_turn", 3);
        tick();
        expect_gnt("prev_low", 0);
        Req = 8'h00;
        tick();
        expect_turn("prev_low_turn", 0);
        tick();

        // long tenure with no Done
        Req = 8'h24;
        tick();
        expect_gnt("hold2", 2);
`ifdef BUS_ARB_TIMEOUT_EN
        tick();
        tick();
        tick();
        expect_gnt("hold2_c4", 2);
        chk("hold2_c4_terr", {31'd0, TimeoutErr}, 32'd0);
        tick();
        expect_turn("to_turn", 2);
        chk("to_terr", {31'd0, TimeoutErr}, 32'd1);
        tick();
        expect_gnt("to_next", 5);
        chk("to_terr_clear", {31'd0, TimeoutErr}, 32'd0);
`else
        repeat (6) tick();
        expect_gnt("hold2_long", 2);
        chk("hold2_long_terr", {31'd0, TimeoutErr}, 32'd0);
        Done = 1'b1;
        tick();
        Done = 1'b0;
        expect_turn("hold2_turn", 2);
        chk("hold2_turn_terr", {31'd0, TimeoutErr}, 32'd0);
        tick();
        expect_gnt("hold_next", 5);
`endif
        Req = 8'h00;
        tick();
        expect_turn("own5_turn", 5);
        tick();

        // Done on the 4th cycle: clean end even at the hold limit
        Req = 8'h04;
        tick();
        expect_gnt("done4", 2);
        tick();
        tick();
        tick();
        Done = 1'b1;
        tick();
        Done = 1'b0;
        Req  = 8'h00;
        expect_turn("done4_turn", 2);
        chk("done4_terr", {31'd0, TimeoutErr}, 32'd0);
        tick();

        // asynchronous reset mid-tenure of owner 6
        Req = 8'h40;
        tick();
        expect_gnt("own6", 6);
        tick();
        #2;
        Reset_n = 1'b0;
        #1;
        chk("abort_gnt", {24'd0, Gnt}, 32'd0);
        chk("abort_valid", {31'd0, BusValid}, 32'd0);
        chk("abort_sel", {29'd0, Sel}, 32'd0);
        chk("abort_terr", {31'd0, TimeoutErr}, 32'd0);
        Req = 8'h41;
        @(posedge Clk);
        #1;
        chk("abort_hold_gnt", {24'd0, Gnt}, 32'd0);
        #1;
        Reset_n = 1'b1;
        tick();
        expect_gnt("post_rst", 0);
        chk("post_rst_terr", {31'd0, TimeoutErr}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bus_arbiter8.md
BUS_ARBITER8 -- requirements
Module: bus_arbiter8

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 16, giving the maximum GRANT cycles per tenure (range 2..255).
REQ-002 The block SHALL have parameter CNT_WIDTH, default 8, giving the hold-counter width, which must hold MAX_HOLD.
REQ-003 Port Clk SHALL be an input, 1 bit wide: the single clock; all state updates on its rising edge.
REQ-004 Port Reset_n SHALL be an input, 1 bit wide: asynchronous, active-low reset.
REQ-005 Port Req SHALL be an input, 8 bits wide: bit i is requester i asking for the shared unidirectional bus.
REQ-006 Port Done SHALL be an input, 1 bit wide: the current owner ends its tenure; valid only while BusValid=1.
REQ-007 Port Gnt SHALL be an output, 8 bits wide: one-hot or zero grant, registered.
REQ-008 Port Sel SHALL be an output, 3 bits wide: binary index of the owner, driving the 8-to-1 bus mux select; requester i is wired to the mux input that Sel=i selects.
REQ-009 Port BusValid SHALL be an output, 1 bit wide: mux output carries owner data this cycle.
REQ-010 Port TimeoutErr SHALL be an output, 1 bit wide: one-cycle pulse on a forced release.

Function
REQ-011 The FSM SHALL have exactly the states IDLE, GRANT and TURN.
REQ-012 In IDLE or TURN with Req!=0, the block SHALL pick a winner by round-robin, searching from index (Last+1) mod 8 upward with wrap, and enter GRANT next cycle (latency 1 from sampled Req).
REQ-013 With Req==0, IDLE SHALL stay IDLE, and TURN SHALL go to IDLE.
REQ-014 On entering GRANT, Gnt SHALL become one-hot of the winner, Sel SHALL equal the winner index, BusValid SHALL be 1, Last SHALL equal the winner, and the hold counter SHALL load 1.
REQ-015 In GRANT, Sel and Gnt SHALL be stable; Req changes of non-owners SHALL be ignored.
REQ-016 In GRANT, Done=1 or Req[Sel]=0 SHALL cause a move to TURN next cycle.
REQ-017 In TURN, Gnt SHALL be 0 and BusValid SHALL be 0 for exactly one cycle (bus turnaround), and Sel SHALL hold its last value.
REQ-018 Sel SHALL change only on entry to GRANT, so the mux select never toggles while BusValid=1.
REQ-019 If the previous owner still requests in TURN, it SHALL get lowest priority; it wins only if no other Req bit is set.
REQ-020 Gnt SHALL never have more than one bit set; BusValid SHALL equal |Gnt.

Reset
REQ-021 On Reset_n=0, outputs SHALL clear immediately, regardless of clock: Gnt=0, Sel=0, BusValid=0, TimeoutErr=0, state=IDLE, counter=0.
REQ-022 On reset, Last SHALL be 7, so requester 0 has highest priority first.
REQ-023 A reset during GRANT SHALL abort the tenure with no TURN cycle and no TimeoutErr.
REQ-024 The first arbitration after reset release SHALL occur at the first rising edge with Reset_n=1.

Configuration
REQ-025 With macro BUS_ARB_TIMEOUT_EN defined, the counter SHALL increment each GRANT cycle; when it equals MAX_HOLD with Done=0 and Req[Sel]=1, the block SHALL go to TURN with TimeoutErr=1 for that TURN cycle.
REQ-026 With BUS_ARB_TIMEOUT_EN defined, if Done and the timeout coincide, Done SHALL win and TimeoutErr SHALL stay 0.
REQ-027 Without BUS_ARB_TIMEOUT_EN, there SHALL be no counter, TimeoutErr SHALL be tied 0, and a tenure SHALL end only via Done or Req drop; MAX_HOLD and CNT_WIDTH SHALL be ignored.

Structure
REQ-028 Shared package bus_arb_pkg SHALL hold: the state typedef (IDLE, GRANT, TURN), NUM_REQ=8 and SEL_WIDTH=3.
REQ-029 Sub-module rr_pick8 SHALL be combinational: inputs Req[7:0] and Last[2:0]; outputs Any and Idx[2:0] (rotate, priority-encode, un-rotate).
REQ-030 The FSM, counter, and output registers SHALL reside in bus_arbiter8.

Verification
REQ-031 Reset release, then Req=8'h01 -> next cycle Gnt=8'h01, Sel=0, BusValid=1.
REQ-032 Req=8'hFF held, each owner pulses Done on its 3rd GRANT cycle -> grant order 0,1,...,7,0, each tenure followed by one TURN cycle with BusValid=0.
REQ-033 Owner 3 granted, Req=8'h08 only, drops Req[3] -> TURN, then IDLE; Sel stays 3.
REQ-034 BUS_ARB_TIMEOUT_EN defined, MAX_HOLD=4, Req=8'h24 held, no Done -> owner 2 held 4 cycles, TimeoutErr pulse, then owner 5 granted.
REQ-035 Reset_n low mid-GRANT of owner 6 -> Gnt=0, BusValid=0 immediately; after release with Req=8'h41, owner 0 wins.
REQ-036 BUS_ARB_TIMEOUT_EN defined, MAX_HOLD=4, Done asserted on cycle 4 -> TURN with TimeoutErr=0.
